// File: rtl/rasterint_gen_if.sv
// Bus bundle for rasterint_gen: video timing, interrupt enables, Z80 ack
// strobes in; INT and raster-origin flag out.
interface rasterint_gen_if;
  logic       cpu_clken;
  logic [8:0] hc;
  logic [8:0] vc;
  logic       rasterint_enable;
  logic       vretraceint_disable;
  logic [8:0] raster_line;
  logic       m1_n;
  logic       iorq_n;
  logic       int_n;
  logic       raster_int_in_progress;

  modport slave (
    input  cpu_clken, hc, vc, rasterint_enable, vretraceint_disable,
           raster_line, m1_n, iorq_n,
    output int_n, raster_int_in_progress
  );

  modport master (
    output cpu_clken, hc, vc, rasterint_enable, vretraceint_disable,
           raster_line, m1_n, iorq_n,
    input  int_n, raster_int_in_progress
  );
endinterface

// File: rtl/rasterint_gen.sv
// Z80 INT generator: vertical-retrace and raster-line interrupts with pending
// queueing. Define INTACK_CLEAR_EN to let an M1+IORQ acknowledge end a pulse.
module rasterint_gen #(
  parameter int unsigned VRETRACE_LINE = 248,
  parameter int unsigned VRETRACE_HC   = 0,
  parameter int unsigned RASTER_HC     = 256,
  parameter int unsigned INT_WIDTH     = 32,
  parameter int unsigned MAX_LINE      = 311
) (
  input  logic             clk,
  input  logic             rst_n,
  rasterint_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, VR_ACTIVE, RAS_ACTIVE} state_t;

  localparam logic [8:0] VR_LINE_C  = 9'(VRETRACE_LINE);
  localparam logic [8:0] VR_HC_C    = 9'(VRETRACE_HC);
  localparam logic [8:0] RAS_HC_C   = 9'(RASTER_HC);
  localparam logic [8:0] MAX_LINE_C = 9'(MAX_LINE);
  localparam logic [5:0] CNT_LAST   = 6'(INT_WIDTH - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       pend_vr_q, pend_vr_d;
  logic       pend_ras_q, pend_ras_d;
  logic       fired_vr_q, fired_ras_q;
  logic       int_n_q, int_n_d;
  logic       rip_q, rip_d;

  logic match_vr, match_ras, req_vr, req_ras, ack;

  assign match_vr  = (bus.vc == VR_LINE_C) && (bus.hc == VR_HC_C) &&
                     !bus.vretraceint_disable;
  assign match_ras = (bus.vc == bus.raster_line) && (bus.hc == RAS_HC_C) &&
                     bus.rasterint_enable && (bus.raster_line <= MAX_LINE_C);

  // Rising edge of each match only, so a held match yields one request.
  assign req_vr  = match_vr  && !fired_vr_q;
  assign req_ras = match_ras && !fired_ras_q;

`ifdef INTACK_CLEAR_EN
  assign ack = !bus.m1_n && !bus.iorq_n && bus.cpu_clken;
`else
  assign ack = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_vr_d  = pend_vr_q;
    pend_ras_d = pend_ras_q;
    unique case (state_q)
      VR_ACTIVE, RAS_ACTIVE: begin
        pend_vr_d  = pend_vr_q  | req_vr;
        pend_ras_d = pend_ras_q | req_ras;
        if (ack || (bus.cpu_clken && cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.cpu_clken) begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        // Retrace wins; a simultaneous raster request is parked as pending.
        if (req_vr || pend_vr_q) begin
          state_d    = VR_ACTIVE;
          pend_vr_d  = 1'b0;
          pend_ras_d = pend_ras_q | req_ras;
        end else if (req_ras || pend_ras_q) begin
          state_d    = RAS_ACTIVE;
          pend_ras_d = 1'b0;
        end
      end
    endcase
    if (!bus.rasterint_enable)   pend_ras_d = 1'b0;
    if (bus.vretraceint_disable) pend_vr_d  = 1'b0;
    int_n_d = (state_d == IDLE);
    rip_d   = (state_d == RAS_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_vr_q   <= 1'b0;
      pend_ras_q  <= 1'b0;
      fired_vr_q  <= 1'b0;
      fired_ras_q <= 1'b0;
      int_n_q     <= 1'b1;
      rip_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vr_q   <= pend_vr_d;
      pend_ras_q  <= pend_ras_d;
      fired_vr_q  <= match_vr;
      fired_ras_q <= match_ras;
      int_n_q     <= int_n_d;
      rip_q       <= rip_d;
    end
  end

  assign bus.int_n                  = int_n_q;
  assign bus.raster_int_in_progress = rip_q;

endmodule

// File: tb/tb_rasterint_gen.sv
// Self-checking bench for rasterint_gen: directed vector table, corner-case
// sequences and a randomized run against a behavioural INT model.
module tb_rasterint_gen;

  localparam int unsigned VR_LINE = 248;
  localparam int unsigned VR_HC   = 0;
  localparam int unsigned RAS_HC  = 0;
  localparam int unsigned W       = 32;
  localparam int unsigned MAXL    = 311;

`ifdef INTACK_CLEAR_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rasterint_gen_if ifc ();

  rasterint_gen #(
    .VRETRACE_LINE(VR_LINE),
    .VRETRACE_HC  (VR_HC),
    .RASTER_HC    (RAS_HC),
    .INT_WIDTH    (W),
    .MAX_LINE     (MAXL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: current source (0 none, 1 retrace, 2 raster), ticks
  // remaining in the pulse, pending and previous-match bits.
  int m_src  = 0;
  int m_left = 0;
  bit p_vr, p_ras, f_vr, f_ras;
  bit mv, mr, nv, nr, m_ack;

  always @(posedge clk) begin
    mv = (ifc.vc == VR_LINE) && (ifc.hc == VR_HC) && !ifc.vretraceint_disable;
    mr = (ifc.vc == ifc.raster_line) && (ifc.hc == RAS_HC) &&
         ifc.rasterint_enable && (ifc.raster_line <= MAXL);
    nv = mv && !f_vr;
    nr = mr && !f_ras;
    m_ack = !ifc.m1_n && !ifc.iorq_n && ifc.cpu_clken && ACK_EN;
    if (!rst_n) begin
      m_src = 0; m_left = 0; p_vr = 0; p_ras = 0; f_vr = 0; f_ras = 0;
    end else begin
      f_vr = mv;
      f_ras = mr;
      if (m_src != 0) begin
        if (nv) p_vr = 1;
        if (nr) p_ras = 1;
        if (ifc.cpu_clken) m_left = m_left - 1;
        if (m_left == 0 || m_ack) m_src = 0;
      end else if (nv || p_vr) begin
        m_src = 1; m_left = W; p_vr = 0;
        if (nr) p_ras = 1;
      end else if (nr || p_ras) begin
        m_src = 2; m_left = W; p_ras = 0;
      end
      if (!ifc.rasterint_enable) p_ras = 0;
      if (ifc.vretraceint_disable) p_vr = 0;
    end
  end

  typedef struct {
    string      name;
    logic [8:0] vc;
    logic [8:0] hc;
    logic [8:0] rl;
    bit         ras_en;
    bit         vr_dis;
    int         hold;
    int         exp_low;
    int         exp_ras;
    int         exp_first;
  } vec_t;

  vec_t tbl[6];

  task automatic park();
    ifc.vc = 9'd0;
    ifc.hc = 9'd1;
    ifc.cpu_clken = 1'b1;
    ifc.m1_n = 1'b1;
    ifc.iorq_n = 1'b1;
  endtask

  int lows, rass, first;

  initial begin
    park();
    ifc.rasterint_enable = 1'b0;
    ifc.vretraceint_disable = 1'b0;
    ifc.raster_line = 9'd100;
    repeat (3) @(negedge clk);
    check("reset_int_n", int'(ifc.int_n), 1);
    check("reset_rip", int'(ifc.raster_int_in_progress), 0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{"vretrace",   9'd248, 9'd0, 9'd100, 1'b0, 1'b0, 4, 32, 0, 0};
    tbl[1] = '{"raster",     9'd100, 9'd0, 9'd100, 1'b1, 1'b0, 4, 32, 32, 0};
    tbl[2] = '{"collision",  9'd248, 9'd0, 9'd248, 1'b1, 1'b0, 4, 64, 32, 0};
    tbl[3] = '{"rl_range",   9'd312, 9'd0, 9'd312, 1'b1, 1'b0, 4, 0, 0, -1};
    tbl[4] = '{"vr_disable", 9'd248, 9'd0, 9'd100, 1'b0, 1'b1, 4, 0, 0, -1};
    tbl[5] = '{"hc_miss",    9'd100, 9'd5, 9'd100, 1'b1, 1'b0, 4, 0, 0, -1};

    for (int i = 0; i < 6; i++) begin
      ifc.raster_line = tbl[i].rl;
      ifc.rasterint_enable = tbl[i].ras_en;
      ifc.vretraceint_disable = tbl[i].vr_dis;
      ifc.vc = tbl[i].vc;
      ifc.hc = tbl[i].hc;
      lows = 0; rass = 0; first = -1;
      for (int c = 0; c < 90; c++) begin
        if (c == tbl[i].hold) park();
        @(negedge clk);
        if (!ifc.int_n) begin
          if (first < 0) first = c;
          lows++;
        end
        if (ifc.raster_int_in_progress) rass++;
      end
      check({tbl[i].name, "_low"}, lows, tbl[i].exp_low);
      check({tbl[i].name, "_ras"}, rass, tbl[i].exp_ras);
      check({tbl[i].name, "_first"}, first, tbl[i].exp_first);
    end

    // Full frame with out-of-range raster line and retrace disabled.
    ifc.raster_line = 9'd312;
    ifc.rasterint_enable = 1'b1;
    ifc.vretraceint_disable = 1'b1;
    lows = 0;
    for (int v = 0; v < 312; v++) begin
      for (int h = 0; h < 2; h++) begin
        ifc.vc = 9'(v);
        ifc.hc = 9'(h);
        @(negedge clk);
        if (!ifc.int_n) lows++;
      end
    end
    check("frame_no_int", lows, 0);
    park();
    ifc.vretraceint_disable = 1'b0;

    // Reset at tick 10 of a raster pulse.
    ifc.raster_line = 9'd100;
    ifc.vc = 9'd100;
    ifc.hc = 9'd0;
    @(negedge clk);
    check("rst_pulse_started", int'(ifc.int_n), 0);
    park();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_int_n", int'(ifc.int_n), 1);
    check("rst_rip", int'(ifc.raster_int_in_progress), 0);
    rst_n = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!ifc.int_n) lows++;
    end
    check("rst_no_resume", lows, 0);

    // Raster pending behind a retrace pulse, then enable dropped.
    ifc.raster_line = 9'd248;
    ifc.vc = 9'd248;
    ifc.hc = 9'd0;
    lows = 0; rass = 0;
    for (int c = 0; c < 90; c++) begin
      if (c == 1) park();
      if (c == 5) ifc.rasterint_enable = 1'b0;
      @(negedge clk);
      if (!ifc.int_n) lows++;
      if (ifc.raster_int_in_progress) rass++;
    end
    check("endrop_low", lows, 32);
    check("endrop_ras", rass, 0);
    ifc.rasterint_enable = 1'b1;

    // Acknowledge at tick 5 of a raster pulse.
    ifc.raster_line = 9'd100;
    ifc.vc = 9'd100;
    ifc.hc = 9'd0;
    lows = 0; rass = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 1) park();
      ifc.m1_n = (c == 5) ? 1'b0 : 1'b1;
      ifc.iorq_n = (c == 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 5) check("ack_edge_int_n", int'(ifc.int_n), ACK_EN ? 1 : 0);
      if (!ifc.int_n) lows++;
      if (ifc.raster_int_in_progress) rass++;
    end
    check("ack_low", lows, ACK_EN ? 5 : 32);
    check("ack_ras", rass, ACK_EN ? 5 : 32);

    // Randomized run against the model.
    park();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) ifc.vc = 9'd248;
      else if (r < 6) ifc.vc = ifc.raster_line;
      else ifc.vc = 9'($urandom_range(0, 311));
      ifc.hc = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'd0;
      if ($urandom_range(0, 199) == 0) ifc.raster_line = 9'($urandom_range(0, 320));
      if ($urandom_range(0, 99) == 0) ifc.rasterint_enable = ~ifc.rasterint_enable;
      if ($urandom_range(0, 99) == 0) ifc.vretraceint_disable = ~ifc.vretraceint_disable;
      ifc.cpu_clken = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 19));
      ifc.m1_n = (r != 0);
      ifc.iorq_n = (r != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      @(negedge clk);
      check("rand_int_n", int'(ifc.int_n), (m_src == 0) ? 1 : 0);
      check("rand_rip", int'(ifc.raster_int_in_progress), (m_src == 2) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
